// File: rtl/hamming_acc.sv
// Hamming-distance accumulator: counts the set bits across a stream of XOR words.
// Popcount and saturating-accumulate stages are registered; the result is held until the consumer takes it.
module hamming_acc #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   input  logic [DATA_WIDTH-1:0] c_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [ACC_WIDTH-1:0]  dist_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  busy_o
);

   localparam int PC_WIDTH = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DRAIN,
      DONE
   } state_t;

   state_t                state;
   logic [LEN_WIDTH-1:0]  remaining;
   logic [ACC_WIDTH-1:0]  acc;
   logic [ACC_WIDTH-1:0]  accNext;
   logic [ACC_WIDTH:0]    sum;
   logic [PC_WIDTH-1:0]   pc;
   logic [PC_WIDTH-1:0]   wordCount;
   logic                  s1_valid;
   logic                  s1_last;
   logic                  accept;
   logic                  lastBeat;

   assign accept   = in_valid_i && in_ready_o;
   assign lastBeat = (remaining == LEN_WIDTH'(1));

   always_comb begin
      wordCount = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         wordCount = wordCount + PC_WIDTH'(c_i[i]);
      end
   end

   // The extra carry bit detects overflow so the accumulator pins at all-ones instead of wrapping.
   always_comb begin
      sum     = {1'b0, acc} + (ACC_WIDTH + 1)'(pc);
      accNext = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc       <= '0;
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
      end else begin
         s1_valid <= accept;
         s1_last  <= accept && lastBeat;
         if (accept) begin
            pc <= wordCount;
         end
      end
   end

   // Control FSM and stage 2; a fresh start clears acc after any stage-2 update in the same cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         remaining   <= '0;
         acc         <= '0;
         in_ready_o  <= 1'b0;
         out_valid_o <= 1'b0;
         busy_o      <= 1'b0;
         dist_o      <= '0;
      end else begin
         if (s1_valid) begin
            acc <= accNext;
         end
         if (accept) begin
            remaining <= remaining - LEN_WIDTH'(1);
         end
         case (state)
            IDLE: begin
               if (start_i) begin
                  acc    <= '0;
                  busy_o <= 1'b1;
                  if (len_i != '0) begin
                     remaining  <= len_i;
                     in_ready_o <= 1'b1;
                     state      <= ACCUM;
                  end else begin
                     dist_o      <= '0;
                     out_valid_o <= 1'b1;
                     state       <= DONE;
                  end
               end
            end
            ACCUM: begin
               if (accept && lastBeat) begin
                  in_ready_o <= 1'b0;
                  state      <= DRAIN;
               end
            end
            DRAIN: begin
               if (s1_valid && s1_last) begin
                  dist_o      <= accNext;
                  out_valid_o <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  out_valid_o <= 1'b0;
                  busy_o      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hamming_acc.sv
// Self-checking bench for hamming_acc: a 32-bit and an 8-bit accumulator instance share one stimulus stream
// and are compared against a bit-count-and-clamp model of each job.
module tb_hamming_acc;

   localparam int DW = 32;
   localparam int LW = 16;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic [LW-1:0] len_i;
   logic [DW-1:0] c_i;
   logic          in_valid_i;
   logic          out_ready_i;

   logic          in_ready_o;
   logic          out_valid_o;
   logic          busy_o;
   logic [31:0]   dist_o;

   logic          inReady8;
   logic          outValid8;
   logic          busy8;
   logic [7:0]    dist8;

   int            checks = 0;
   int            errors = 0;
   logic [31:0]   wordQ[$];
   int            gapQ[$];

   hamming_acc #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .ACC_WIDTH(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .c_i(c_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .dist_o(dist_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o)
   );

   hamming_acc #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .ACC_WIDTH(8)) dut8 (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .c_i(c_i),
      .in_valid_i(in_valid_i), .in_ready_o(inReady8), .dist_o(dist8),
      .out_valid_o(outValid8), .out_ready_i(out_ready_i), .busy_o(busy8)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   // Hamming distance of the whole job, clamped to the largest value a width-bit result can hold.
   function automatic longint modelDist(input int width);
      longint total = 0;
      longint limit;
      limit = (longint'(1) << width) - 1;
      foreach (wordQ[i]) total += $countones(wordQ[i]);
      return (total > limit) ? limit : total;
   endfunction

   task automatic pushBeat(input logic [31:0] word, input int gap);
      wordQ.push_back(word);
      gapQ.push_back(gap);
   endtask

   task automatic clearJob();
      wordQ.delete();
      gapQ.delete();
   endtask

   // Runs one job from the queued words and gaps, then holds the result for readyDelay cycles before taking it.
   task automatic applyStimulus(input int len, input int readyDelay);
      longint exp32;
      longint exp8;
      int     accepted = 0;
      int     idx = 0;
      int     gap;
      int     budget;
      logic   took;
      exp32 = modelDist(32);
      exp8  = modelDist(8);
      start_i = 1'b1;
      len_i   = LW'(len);
      cycle();
      start_i = 1'b0;
      checkOutput("busy_after_start", busy_o, 1);
      if (len == 0) begin
         checkOutput("len0_out_valid", out_valid_o, 1);
         checkOutput("len0_dist", dist_o, 0);
         checkOutput("len0_in_ready", in_ready_o, 0);
      end else begin
         gap = gapQ[0];
         budget = len * 20 + 50;
         while (accepted < len && budget > 0) begin
            checkOutput("in_ready_open", in_ready_o, 1);
            checkOutput("in_ready_open_8", inReady8, 1);
            if (gap > 0) begin
               in_valid_i = 1'b0;
               gap--;
            end else begin
               in_valid_i = 1'b1;
               c_i = wordQ[idx];
            end
            took = in_valid_i && in_ready_o;
            cycle();
            if (took) begin
               accepted++;
               idx++;
               if (idx < len) gap = gapQ[idx];
            end
            budget--;
         end
         if (accepted < len) checkOutput("accept_timeout", accepted, len);
         in_valid_i = 1'b1;
         c_i = '1;
         checkOutput("in_ready_closed", in_ready_o, 0);
         checkOutput("out_valid_early", out_valid_o, 0);
         checkOutput("busy_drain", busy_o, 1);
         cycle();
         checkOutput("out_valid_latency", out_valid_o, 1);
         checkOutput("out_valid_latency_8", outValid8, 1);
      end
      checkOutput("dist", dist_o, exp32);
      checkOutput("dist_8", dist8, exp8);
      for (int k = 0; k < readyDelay; k++) begin
         out_ready_i = 1'b0;
         start_i = (k == 0);
         len_i = LW'(5);
         cycle();
         checkOutput("hold_out_valid", out_valid_o, 1);
         checkOutput("hold_dist", dist_o, exp32);
         checkOutput("hold_dist_8", dist8, exp8);
      end
      start_i = 1'b0;
      out_ready_i = 1'b1;
      cycle();
      out_ready_i = 1'b0;
      in_valid_i = 1'b0;
      checkOutput("out_valid_drop", out_valid_o, 0);
      checkOutput("busy_drop", busy_o, 0);
      checkOutput("dist_kept", dist_o, exp32);
      checkOutput("in_ready_idle", in_ready_o, 0);
      cycle();
      checkOutput("still_idle", busy_o, 0);
   endtask

   initial begin
      int len;
      rst_i = 1'b1;
      start_i = 1'b0;
      len_i = '0;
      c_i = '0;
      in_valid_i = 1'b0;
      out_ready_i = 1'b0;
      cycle();
      cycle();
      checkOutput("reset_in_ready", in_ready_o, 0);
      checkOutput("reset_out_valid", out_valid_o, 0);
      checkOutput("reset_busy", busy_o, 0);
      checkOutput("reset_dist", dist_o, 0);
      rst_i = 1'b0;
      cycle();

      $display("[TB] single all-ones word");
      clearJob();
      pushBeat(32'hFFFF_FFFF, 0);
      applyStimulus(1, 0);

      $display("[TB] four back-to-back words");
      clearJob();
      pushBeat(32'h0000_0001, 0);
      pushBeat(32'h0000_0003, 0);
      pushBeat(32'h0000_0000, 0);
      pushBeat(32'h8000_0000, 0);
      applyStimulus(4, 1);

      $display("[TB] gapped beats");
      clearJob();
      pushBeat(32'hF0F0_F0F0, 0);
      pushBeat(32'hF0F0_F0F0, 2);
      pushBeat(32'hF0F0_F0F0, 5);
      applyStimulus(3, 0);

      $display("[TB] zero-length job");
      clearJob();
      applyStimulus(0, 2);

      $display("[TB] held result with start pulse");
      clearJob();
      pushBeat($urandom, 0);
      pushBeat($urandom, 1);
      applyStimulus(2, 6);

      $display("[TB] saturation on narrow accumulator");
      clearJob();
      for (int i = 0; i < 10; i++) pushBeat(32'hFFFF_FFFF, 0);
      applyStimulus(10, 0);

      $display("[TB] reset mid-job");
      start_i = 1'b1;
      len_i = LW'(8);
      cycle();
      start_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid_i = 1'b1;
         c_i = 32'hFFFF_FFFF;
         cycle();
      end
      in_valid_i = 1'b0;
      rst_i = 1'b1;
      cycle();
      rst_i = 1'b0;
      checkOutput("abort_in_ready", in_ready_o, 0);
      checkOutput("abort_out_valid", out_valid_o, 0);
      checkOutput("abort_busy", busy_o, 0);
      checkOutput("abort_dist", dist_o, 0);
      checkOutput("abort_dist_8", dist8, 0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         checkOutput("abort_no_valid", out_valid_o, 0);
      end
      clearJob();
      pushBeat(32'h0000_FFFF, 0);
      applyStimulus(1, 0);

      $display("[TB] random jobs");
      for (int j = 0; j < 10; j++) begin
         clearJob();
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) begin
            pushBeat(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom_range(0, 3));
         end
         applyStimulus(len, $urandom_range(0, 4));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
